// File: rtl/fft_bf_addr_gen_pkg.sv
// Shared constants, FSM encoding and a width helper for the FFT address sequencer.
package fft_bf_addr_gen_pkg;

  localparam int LOGN = 4;
  localparam int N    = 1 << LOGN;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of the stage index; kept at least one bit wide.
  localparam int STG_W = (clog2(LOGN) < 1) ? 1 : clog2(LOGN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register used to age read strobes/addresses into write strobes.
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] taps;

  // Shift one tap per clock; reset empties the line so no stale strobe survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_bf_addr_gen.sv
// In-place radix-2 DIF FFT address sequencer: read/twiddle addresses per butterfly,
// delayed write-back addresses, stage sequencing with a drain gap between stages.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for start; all strobes low
//  ST_RUN   | one butterfly read per cycle, k = 0 .. N/2-1 of stage s
//  ST_DRAIN | E_LAT cycles with no reads so the stage's last writes land
module fft_bf_addr_gen
  import fft_bf_addr_gen_pkg::*;
#(
  parameter int D_LAT = 2,
  parameter int E_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOGN-1:0]  rd_addr_a,
  output logic [LOGN-1:0]  rd_addr_b,
  output logic [LOGN-2:0]  tw_addr,
  output logic             wd_en,
  output logic [LOGN-1:0]  wd_addr,
  output logic             we_en,
  output logic [LOGN-1:0]  we_addr,
  output logic [STG_W-1:0] stage
);

  localparam int TW_W = LOGN - 1;
  localparam int DC_W = (clog2(E_LAT + 1) < 1) ? 1 : clog2(E_LAT + 1);
  localparam logic [TW_W-1:0]  K_LAST  = '1;
  localparam logic [STG_W-1:0] S_LAST  = STG_W'(LOGN - 1);
  localparam logic [DC_W-1:0]  DC_LOAD = DC_W'(E_LAT - 1);

  state_t            state, state_n;
  logic [TW_W-1:0]   k, k_n;
  logic [STG_W-1:0]  s, s_n;
  logic [DC_W-1:0]   dcnt, dcnt_n;
  logic              done_n;
  logic              run_n;
  logic [LOGN-1:0]   addr_a_n, addr_b_n;
  logic [TW_W-1:0]   tw_n;
  int                si, ki, span, grp, j, a_int;
  logic [LOGN:0]     dl_d_q, dl_e_q;

  // FSM state, butterfly index, stage index and drain down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      k     <= '0;
      s     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      s     <= s_n;
      dcnt  <= dcnt_n;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_n = state;
    k_n     = k;
    s_n     = s;
    dcnt_n  = dcnt;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          k_n     = '0;
          s_n     = '0;
        end
      end
      ST_RUN: begin
        if (k == K_LAST) begin
          state_n = ST_DRAIN;
          dcnt_n  = DC_LOAD;
        end else begin
          k_n = k + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dcnt == '0) begin
          k_n = '0;
          if (s == S_LAST) begin
            state_n = ST_IDLE;
            s_n     = '0;
            done_n  = 1'b1;
          end else begin
            state_n = ST_RUN;
            s_n     = s + 1'b1;
          end
        end else begin
          dcnt_n = dcnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Butterfly addresses for the upcoming cycle, shifts and masks only.
  always_comb begin
    si       = int'(s_n);
    ki       = int'(k_n);
    span     = N >> (si + 1);
    grp      = ki >> (LOGN - 1 - si);
    j        = ki & (span - 1);
    a_int    = (grp << (LOGN - si)) + j;
    run_n    = (state_n == ST_RUN);
    addr_a_n = LOGN'(a_int);
    addr_b_n = LOGN'(a_int + span);
    tw_n     = TW_W'(j << si);
  end

  // Registered outputs, driven from next-state values so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
    end else begin
      rd_en     <= run_n;
      rd_addr_a <= run_n ? addr_a_n : '0;
      rd_addr_b <= run_n ? addr_b_n : '0;
      tw_addr   <= run_n ? tw_n : '0;
      busy      <= (state_n != ST_IDLE);
      done      <= done_n;
      stage     <= s_n;
    end
  end

  fft_delay_line #(.WIDTH(LOGN + 1), .DEPTH(D_LAT)) u_dl_d (
    .clk   (clk),
    .reset (reset),
    .din   ({rd_en, rd_addr_a}),
    .dout  (dl_d_q)
  );

  fft_delay_line #(.WIDTH(LOGN + 1), .DEPTH(E_LAT)) u_dl_e (
    .clk   (clk),
    .reset (reset),
    .din   ({rd_en, rd_addr_b}),
    .dout  (dl_e_q)
  );

  assign wd_en   = dl_d_q[LOGN];
  assign wd_addr = dl_d_q[LOGN-1:0];
  assign we_en   = dl_e_q[LOGN];
  assign we_addr = dl_e_q[LOGN-1:0];

endmodule

// File: tb/tb_fft_bf_addr_gen.sv
// Scoreboard bench for fft_bf_addr_gen: a driver pushes expected read/write events
// per transform, a negedge monitor pops and compares, and a butterfly/RAM model
// runs an impulse through the issued addresses.
module tb_fft_bf_addr_gen;

  localparam int LOGN  = 4;
  localparam int N     = 16;
  localparam int D_LAT = 2;
  localparam int E_LAT = 4;
  localparam int STAGE_CYC = N / 2 + E_LAT;
  localparam int TOTAL_CYC = LOGN * STAGE_CYC;
  localparam real PI = 3.14159265358979323846;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            busy, done, rd_en, wd_en, we_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wd_addr, we_addr;
  logic [LOGN-2:0] tw_addr;
  logic [1:0]      stage;

  fft_bf_addr_gen #(.D_LAT(D_LAT), .E_LAT(E_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wd_en     (wd_en),
    .wd_addr   (wd_addr),
    .we_en     (we_en),
    .we_addr   (we_addr),
    .stage     (stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int a; int b; int tw; int s;} rd_ev_t;
  typedef struct {int c; int addr;} wr_ev_t;

  rd_ev_t rd_q[$];
  wr_ev_t wd_q[$];
  wr_ev_t we_q[$];
  int     starts[$];
  real    d_re_q[$], d_im_q[$], e_re_q[$], e_im_q[$];
  real    ram_re[N], ram_im[N];

  int nchk = 0;
  int nerr = 0;
  int n_rd = 0, n_wd = 0, n_we = 0;
  bit fft_checked = 1'b0;

  task automatic check_int(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic bit exp_busy(input int c);
    foreach (starts[i]) if (c >= starts[i] && c < starts[i] + TOTAL_CYC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_done(input int c);
    foreach (starts[i]) if (c == starts[i] + TOTAL_CYC) return 1'b1;
    return 1'b0;
  endfunction

  // Reference schedule from the DIF address rules, written with plain arithmetic.
  task automatic push_transform(input int t0);
    int span, g, j, a;
    for (int s = 0; s < LOGN; s++) begin
      for (int k = 0; k < N / 2; k++) begin
        span = N / (2 ** (s + 1));
        g    = k / span;
        j    = k % span;
        a    = g * 2 * span + j;
        rd_q.push_back('{t0 + s * STAGE_CYC + k, a, a + span, (j * (2 ** s)) % (N / 2), s});
        wd_q.push_back('{t0 + s * STAGE_CYC + k + D_LAT, a});
        we_q.push_back('{t0 + s * STAGE_CYC + k + E_LAT, a + span});
      end
    end
  endtask

  task automatic do_start(output int t0);
    t0 = cyc + 1;
    push_transform(t0);
    starts.push_back(t0);
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic pulse_start_only();
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string name);
    check_int(name, int'({busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                          wd_en, wd_addr, we_en, we_addr, stage}), 0);
  endtask

  rd_ev_t rev;
  wr_ev_t wev;
  real ar, ai, br, bi, dr, di, wr, wi;

  // Monitor: writes land first, then reads, then busy/done against the schedule.
  always @(negedge clk) begin
    if (wd_en) begin
      n_wd++;
      if (wd_q.size() == 0) check_int("wd_unexpected", 1, 0);
      else begin
        wev = wd_q.pop_front();
        check_int("wd_cycle", cyc, wev.c);
        check_int("wd_addr", int'(wd_addr), wev.addr);
      end
      if (d_re_q.size() > 0) begin
        ram_re[wd_addr] = d_re_q.pop_front();
        ram_im[wd_addr] = d_im_q.pop_front();
      end
    end
    if (we_en) begin
      n_we++;
      if (we_q.size() == 0) check_int("we_unexpected", 1, 0);
      else begin
        wev = we_q.pop_front();
        check_int("we_cycle", cyc, wev.c);
        check_int("we_addr", int'(we_addr), wev.addr);
      end
      if (e_re_q.size() > 0) begin
        ram_re[we_addr] = e_re_q.pop_front();
        ram_im[we_addr] = e_im_q.pop_front();
      end
    end
    if (rd_en) begin
      n_rd++;
      if (rd_q.size() == 0) check_int("rd_unexpected", 1, 0);
      else begin
        rev = rd_q.pop_front();
        check_int("rd_cycle", cyc, rev.c);
        check_int("rd_addr_a", int'(rd_addr_a), rev.a);
        check_int("rd_addr_b", int'(rd_addr_b), rev.b);
        check_int("tw_addr", int'(tw_addr), rev.tw);
        check_int("stage", int'(stage), rev.s);
      end
      ar = ram_re[rd_addr_a]; ai = ram_im[rd_addr_a];
      br = ram_re[rd_addr_b]; bi = ram_im[rd_addr_b];
      wr = $cos(2.0 * PI * real'(tw_addr) / real'(N));
      wi = -$sin(2.0 * PI * real'(tw_addr) / real'(N));
      dr = ar - br; di = ai - bi;
      d_re_q.push_back((ar + br) / 2.0);
      d_im_q.push_back((ai + bi) / 2.0);
      e_re_q.push_back((dr * wr - di * wi) / 2.0);
      e_im_q.push_back((dr * wi + di * wr) / 2.0);
    end
    check_int("busy", int'(busy), int'(exp_busy(cyc)));
    check_int("done", int'(done), int'(exp_done(cyc)));
    if (done) begin
      check_int("n_rd", n_rd, N / 2 * LOGN);
      check_int("n_wd", n_wd, N / 2 * LOGN);
      check_int("n_we", n_we, N / 2 * LOGN);
      n_rd = 0; n_wd = 0; n_we = 0;
      if (!fft_checked) begin
        fft_checked = 1'b1;
        for (int b = 0; b < N; b++) begin
          check_int($sformatf("bin%0d_re_x1000", b), rnd(ram_re[b] * 1000.0), 4000);
          check_int($sformatf("bin%0d_im_x1000", b), rnd(ram_im[b] * 1000.0), 0);
        end
      end
    end
  end

  int t0, t1, t2, tl;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      ram_re[i] = 0.0;
      ram_im[i] = 0.0;
    end
    ram_re[0] = 64.0;
    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset_outputs");
    reset = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    #2;

    // Transform 1 with a stray start during stage 1, then a start in its done cycle.
    do_start(t0);
    wait_cyc(t0 + STAGE_CYC + $urandom_range(0, 6));
    pulse_start_only();
    wait_cyc(t0 + TOTAL_CYC);
    check_int("done_in_b2b_cycle", int'(done), 1);
    do_start(t1);

    // Abort transform 2 inside the stage-2 drain.
    wait_cyc(t1 + 2 * STAGE_CYC + N / 2 + 1);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset_outputs");
    rd_q.delete(); wd_q.delete(); we_q.delete(); starts.delete();
    d_re_q.delete(); d_im_q.delete(); e_re_q.delete(); e_im_q.delete();
    n_rd = 0; n_wd = 0; n_we = 0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (E_LAT + 4) @(negedge clk);
    #2;

    // Fresh transform plus a few with random gaps.
    do_start(t2);
    tl = t2;
    wait_cyc(t2 + TOTAL_CYC + 1);
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      #2;
      do_start(tl);
      wait_cyc(tl + TOTAL_CYC + 1);
    end
    wait_cyc(tl + TOTAL_CYC + 3);

    check_int("rd_q_left", rd_q.size(), 0);
    check_int("wd_q_left", wd_q.size(), 0);
    check_int("we_q_left", we_q.size(), 0);
    check_int("fft_checked", int'(fft_checked), 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
